// File: rtl/cdb_arbiter_pkg.sv
// Shared rv32i types: CDB broadcast record and
// the sizing constants for the result arbiter.
package rv32i_types;

  localparam int NUM_CDB         = 2;
  localparam int NUM_FU          = 4;
  localparam int CDB_QUEUE_DEPTH = 2;

  typedef struct packed {
    logic        valid;
    logic [5:0]  pd_s;
    logic [31:0] pd_v;
    logic [3:0]  rob_id;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_queue.sv
// Per-unit result FIFO feeding the CDB arbiter.
// Pointers wrap naturally; depth is a power of two.
module cdb_result_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = CDB_QUEUE_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  cdb_t          push_data,
  output cdb_t          head,
  output logic [CW-1:0] count,
  output logic          full
);

  cdb_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to NUM_CDB queued
// FU results per cycle onto the common data bus.
module cdb_arbiter
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NUM_FU-1:0] req_valid,
  input  cdb_t              req_data [NUM_FU],
  output logic [NUM_FU-1:0] req_ready,
  output cdb_t              cdb [NUM_CDB],
  output logic [NUM_FU-1:0] grant
);

  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SW = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;
  localparam int QW = $clog2(CDB_QUEUE_DEPTH) + 1;

  cdb_t              head  [NUM_FU];
  logic [QW-1:0]     count [NUM_FU];
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] push;
  logic [FW-1:0]     rr_ptr;
  logic [FW-1:0]     last;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_q
    cdb_result_queue #(
      .DEPTH(CDB_QUEUE_DEPTH)
    ) u_q (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .push     (push[g]),
      .pop      (grant[g]),
      .push_data(req_data[g]),
      .head     (head[g]),
      .count    (count[g]),
      .full     (full[g])
    );
  end

  // Ready depends only on registered counts, never on this cycle's pop.
  assign req_ready = ~full & {NUM_FU{!rst && !flush}};
  assign push      = req_valid & req_ready;

  always_comb begin
    logic [FW-1:0] idx;
    int            n;
    grant = '0;
    last  = rr_ptr;
    n     = 0;
    idx   = '0;
    for (int k = 0; k < NUM_CDB; k++) cdb[k] = '0;
    if (!rst && !flush) begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = FW'((int'(rr_ptr) + k) % NUM_FU);
        if (count[idx] != '0 && n < NUM_CDB) begin
          grant[idx]         = 1'b1;
          cdb[SW'(n)]        = head[idx];
          cdb[SW'(n)].valid  = 1'b1;
          last               = idx;
          n                  = n + 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= FW'((int'(last) + 1) % NUM_FU);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random
// traffic, compared against a queue-based reference.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int QD = CDB_QUEUE_DEPTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NUM_FU-1:0] req_valid;
  cdb_t              req_data [NUM_FU];
  logic [NUM_FU-1:0] req_ready;
  cdb_t              cdb [NUM_CDB];
  logic [NUM_FU-1:0] grant;

  int errors = 0;
  int checks = 0;

  cdb_t              mq [NUM_FU][$];
  int                mrr;
  logic [NUM_FU-1:0] acc;

  cdb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .cdb      (cdb),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  function automatic cdb_t rnd();
    cdb_t d;
    d.valid  = 1'($urandom);
    d.pd_s   = 6'($urandom);
    d.pd_v   = $urandom;
    d.rob_id = 4'($urandom);
    return d;
  endfunction

  function automatic cdb_t mk(input int s, input logic [31:0] v);
    cdb_t d;
    d        = '0;
    d.pd_s   = 6'(s);
    d.pd_v   = v;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got %0h exp %0h", tag, $time, got, exp);
    end
  endtask

  // One cycle: check outputs against the model, clock, update model.
  task automatic tick();
    logic [NUM_FU-1:0] er;
    logic [NUM_FU-1:0] eg;
    cdb_t              ec [NUM_CDB];
    int                n;
    int                idx;
    int                last;
    #1;
    er = '0;
    eg = '0;
    for (int k = 0; k < NUM_CDB; k++) ec[k] = '0;
    n    = 0;
    last = mrr;
    if (!rst && !flush) begin
      for (int i = 0; i < NUM_FU; i++) er[i] = (mq[i].size() < QD);
      for (int k = 0; k < NUM_FU; k++) begin
        idx = (mrr + k) % NUM_FU;
        if (mq[idx].size() > 0 && n < NUM_CDB) begin
          eg[idx]       = 1'b1;
          ec[n]         = mq[idx][0];
          ec[n].valid   = 1'b1;
          last          = idx;
          n++;
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("grant", 64'(grant), 64'(eg));
    for (int k = 0; k < NUM_CDB; k++)
      chk($sformatf("cdb%0d", k), 64'(cdb[k]), 64'(ec[k]));
    acc = req_valid & er;
    @(posedge clk);
    if (rst || flush) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      if (rst) mrr = 0;
    end else begin
      for (int i = 0; i < NUM_FU; i++)
        if (eg[i]) void'(mq[i].pop_front());
      for (int i = 0; i < NUM_FU; i++)
        if (acc[i]) mq[i].push_back(req_data[i]);
      if (n > 0) mrr = (last + 1) % NUM_FU;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = '0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    int   seq;
    logic seen_full;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NUM_FU; i++) req_data[i] = rnd();
    mrr = 0;
    @(negedge clk);

    // reset held two cycles with every unit requesting
    repeat (2) tick();
    idle();
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'hF);
    chk("post_rst_v0", 64'(cdb[0].valid), 64'h0);
    tick();

    // single result from unit 2
    req_valid   = 4'b0100;
    req_data[2] = mk(7, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("single_grant", 64'(grant), 64'h4);
    chk("single_pdv", 64'(cdb[0].pd_v), 64'hDEADBEEF);
    chk("single_pds", 64'(cdb[0].pd_s), 64'h7);
    chk("single_v1", 64'(cdb[1].valid), 64'h0);
    tick();

    // contention: reset rr_ptr to 0, then all four push at once
    rst = 1'b1;
    tick();
    idle();
    req_valid = '1;
    for (int i = 0; i < NUM_FU; i++) req_data[i] = mk(i + 1, 32'(100 + i));
    tick();
    idle();
    #1;
    chk("cont_g0", 64'(grant), 64'h3);
    tick();
    #1;
    chk("cont_g1", 64'(grant), 64'hC);
    repeat (2) tick();

    // backpressure: unit 0 streams 1,2,3,... while others stay loaded
    seq       = 1;
    seen_full = 1'b0;
    for (int c = 0; c < 40; c++) begin
      req_valid   = '1;
      req_data[0] = mk(1, 32'(seq));
      for (int i = 1; i < NUM_FU; i++) req_data[i] = rnd();
      #1;
      if (!req_ready[0]) seen_full = 1'b1;
      tick();
      if (acc[0]) seq++;
    end
    chk("bp_ready_drop", 64'(seen_full), 64'h1);
    idle();
    repeat (8) tick();

    // simultaneous push and pop on unit 1
    req_valid   = 4'b0010;
    req_data[1] = mk(3, 32'hAAAA0001);
    tick();
    req_data[1] = mk(4, 32'hBBBB0002);
    #1;
    chk("pp_grant", 64'(grant), 64'h2);
    tick();
    idle();
    #1;
    chk("pp_next_pdv", 64'(cdb[0].pd_v), 64'hBBBB0002);
    chk("pp_next_grant", 64'(grant), 64'h2);
    tick();
    tick();

    // flush with loaded queues
    for (int c = 0; c < 4; c++) begin
      req_valid = '1;
      for (int i = 0; i < NUM_FU; i++) req_data[i] = rnd();
      tick();
    end
    flush = 1'b1;
    #1;
    chk("flush_v0", 64'(cdb[0].valid), 64'h0);
    tick();
    idle();
    #1;
    chk("flush_ready", 64'(req_ready), 64'hF);
    repeat (10) tick();

    // random traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < NUM_FU; i++) req_data[i] = rnd();
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 79) == 0);
      tick();
    end
    idle();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
